// File: rtl/pattern_det_ctrl.sv
// Programmable serial pattern detector: IDLE/RUN/DONE frame sequencer with a Mealy match output.
// Define OVERLAP_EN for overlapping detection; the default restarts the search after every match.
module pattern_det_ctrl #(
  parameter int unsigned PAT_W   = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned FRAME_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [PAT_W-1:0]   cfg_pat,
  input  logic [3:0]         cfg_len,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame_len,
  input  logic               abort,
  input  logic               x,
  input  logic               x_valid,
  output logic               y,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               err
);

  // The oldest history bit never reaches the compare window, so it is not stored.
  localparam int unsigned HistW = (PAT_W > 1) ? PAT_W - 1 : 1;
  localparam logic [3:0] PatWL = 4'(PAT_W);
  localparam logic [FRAME_W-1:0] FrameOne = FRAME_W'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state;
  logic [PAT_W-1:0]   pattern;
  logic [3:0]         len;
  logic [HistW-1:0]   history;
  logic [3:0]         seen;
  logic [FRAME_W-1:0] bit_cnt;
  logic [FRAME_W-1:0] frame_q;

  logic [PAT_W-1:0]   shifted;
  logic [PAT_W-1:0]   mask;
  logic               cfg_legal;
  logic               hit;
  logic               last_bit;

  always_comb begin
    shifted    = '0;
    shifted[0] = x;
    for (int i = 1; i < int'(PAT_W); i++) shifted[i] = history[i-1];
    mask = '0;
    for (int i = 0; i < int'(PAT_W); i++) mask[i] = (4'(i) < len);
  end

  assign cfg_legal = (cfg_len != 4'd0) && (cfg_len <= PatWL);
  assign hit = (state == StRun) && x_valid && (({1'b0, seen} + 5'd1) >= {1'b0, len}) &&
               (((shifted ^ pattern) & mask) == '0);
  assign y = hit;
  assign last_bit = (bit_cnt == frame_q - FrameOne);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= StIdle;
      pattern   <= '0;
      len       <= PatWL;
      history   <= '0;
      seen      <= '0;
      bit_cnt   <= '0;
      frame_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      match_cnt <= '0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (cfg_we) begin
            if (cfg_legal) begin
              pattern <= cfg_pat;
              len     <= cfg_len;
              err     <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
          if (start) begin
            match_cnt <= '0;
            if (frame_len != '0) begin
              state   <= StRun;
              busy    <= 1'b1;
              bit_cnt <= '0;
              seen    <= '0;
              history <= '0;
              frame_q <= frame_len;
            end else begin
              state <= StDone;
              done  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (abort) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else if (x_valid) begin
            bit_cnt <= bit_cnt + FrameOne;
            if (hit && (match_cnt != '1)) match_cnt <= match_cnt + 1'b1;
`ifdef OVERLAP_EN
            history <= shifted[HistW-1:0];
            if (seen < PatWL) seen <= seen + 4'd1;
`else
            if (hit) begin
              history <= '0;
              seen    <= '0;
            end else begin
              history <= shifted[HistW-1:0];
              if (seen < PatWL) seen <= seen + 4'd1;
            end
`endif
            if (last_bit) begin
              state <= StDone;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        StDone: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Randomized self-checking bench for pattern_det_ctrl against a queue-based behavioural model.
// A second instance with a 2-bit counter checks match-count saturation on the same stimulus.
module tb_pattern_det_ctrl;

  logic       clk = 1'b0;
  logic       reset, cfg_we, start, abort, x, x_valid;
  logic [3:0] cfg_pat, cfg_len;
  logic [7:0] frame_len;
  logic       y, busy, done, err;
  logic [7:0] match_cnt;
  logic       s_y, s_busy, s_done, s_err;
  logic [1:0] s_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: pattern/len/err and the bits seen since frame start or the last match.
  logic [3:0] m_pat;
  int         m_len;
  logic       m_err;
  int         m_cnt;
  bit         hq[$];

  always #5 clk = ~clk;

  pattern_det_ctrl #(.PAT_W(4), .CNT_W(8), .FRAME_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .start(start), .frame_len(frame_len), .abort(abort), .x(x), .x_valid(x_valid),
    .y(y), .busy(busy), .done(done), .match_cnt(match_cnt), .err(err)
  );

  pattern_det_ctrl #(.PAT_W(4), .CNT_W(2), .FRAME_W(8)) dut_sat (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .start(start), .frame_len(frame_len), .abort(abort), .x(x), .x_valid(x_valid),
    .y(s_y), .busy(s_busy), .done(s_done), .match_cnt(s_cnt), .err(s_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit model_match(input bit b);
    if (hq.size() + 1 < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      bit h;
      h = (i == 0) ? b : hq[hq.size() - i];
      if (h != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic do_cfg(input logic [3:0] pat, input logic [3:0] len);
    cfg_we = 1'b1; cfg_pat = pat; cfg_len = len;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (len >= 1 && len <= 4) begin
      m_pat = pat; m_len = int'(len); m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    check_eq("cfg_err", err, m_err);
  endtask

  // abort_at >= 0 aborts once that many bits are consumed; cfg_in_run pokes an illegal config.
  task automatic do_frame(input int flen, input logic [63:0] vec, input bit use_vec,
                          input int bubble_pct, input int abort_at, input bit cfg_in_run);
    int  consumed;
    int  cycles;
    bit  b;
    bit  ey;
    start = 1'b1; frame_len = 8'(flen);
    @(posedge clk); #1;
    start = 1'b0;
    m_cnt = 0;
    hq.delete();
    if (flen == 0) begin
      check_eq("zl_done", done, 1);
      check_eq("zl_busy", busy, 0);
      check_eq("zl_cnt", match_cnt, 0);
      @(posedge clk); #1;
      check_eq("zl_done_end", done, 0);
      check_eq("zl_busy_end", busy, 0);
      return;
    end
    check_eq("run_busy", busy, 1);
    consumed = 0;
    cycles   = 0;
    while (consumed < flen) begin
      if (cycles > 2000) begin
        check_eq("frame_timeout", consumed, flen);
        return;
      end
      if (abort_at >= 0 && consumed == abort_at) begin
        abort = 1'b1; x_valid = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_cnt", match_cnt, m_cnt);
        @(posedge clk); #1;
        check_eq("abort_done2", done, 0);
        return;
      end
      x_valid = ($urandom_range(99) >= bubble_pct);
      b = use_vec ? vec[consumed] : 1'($urandom_range(1));
      x = x_valid ? b : 1'($urandom_range(1));
      cfg_we = (cfg_in_run && consumed == 1);
      cfg_pat = ~m_pat; cfg_len = 4'd0;
      ey = x_valid && model_match(b);
      #3;
      check_eq("y", y, ey);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      cycles++;
      if (x_valid) begin
        consumed++;
        hq.push_back(b);
        if (ey) begin
          if (m_cnt < 255) m_cnt++;
`ifndef OVERLAP_EN
          hq.delete();
`endif
        end
        if (consumed < flen) check_eq("busy_mid", busy, 1);
      end
    end
    x_valid = 1'b0;
    check_eq("end_done", done, 1);
    check_eq("end_busy", busy, 0);
    check_eq("end_cnt", match_cnt, m_cnt);
    check_eq("end_sat_cnt", s_cnt, sat3(m_cnt));
    check_eq("end_err", err, m_err);
    @(posedge clk); #1;
    check_eq("done_pulse", done, 0);
    check_eq("hold_cnt", match_cnt, m_cnt);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    m_pat = 4'd0; m_len = 4; m_err = 1'b0; m_cnt = 0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cnt", match_cnt, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_y", y, 0);
  endtask

  initial begin
    cfg_we = 0; start = 0; abort = 0; x = 0; x_valid = 0;
    cfg_pat = 0; cfg_len = 0; frame_len = 0;
    reset = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Directed 101 stream, plain then with bubbles.
    do_cfg(4'b0101, 4'd3);
    do_frame(8, 64'hB5, 1'b1, 0, -1, 1'b0);
`ifdef OVERLAP_EN
    check_eq("tp_cnt", match_cnt, 3);
`else
    check_eq("tp_cnt", match_cnt, 2);
`endif
    do_frame(8, 64'hB5, 1'b1, 50, -1, 1'b0);

    // Illegal lengths flag err and keep the 101 pattern; a legal write clears err.
    do_cfg(4'b1111, 4'd0);
    do_frame(8, 64'hB5, 1'b1, 0, -1, 1'b0);
    do_cfg(4'b0011, 4'd5);
    do_cfg(4'b0110, 4'd4);
    do_frame(12, 64'h6D6, 1'b1, 20, -1, 1'b1);

    // Saturation on the 2-bit counter instance.
    do_cfg(4'b0001, 4'd1);
    do_frame(6, 64'h3F, 1'b1, 0, -1, 1'b0);
    check_eq("sat_main", match_cnt, 6);

    do_frame(0, 64'h0, 1'b0, 0, -1, 1'b0);
    do_frame(8, 64'hFF, 1'b1, 0, 3, 1'b0);
    check_eq("abort_partial", match_cnt, 3);

    // Reset mid-frame.
    do_cfg(4'b0101, 4'd3);
    start = 1'b1; frame_len = 8'd8;
    @(posedge clk); #1;
    start = 1'b0; x_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x = 1'(i % 2 == 0);
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
    do_reset();
    @(posedge clk); #1;
    check_eq("rst_no_done", done, 0);

    for (int k = 0; k < 12; k++) begin
      do_cfg(4'($urandom_range(15)), 4'($urandom_range(1, 4)));
      do_frame($urandom_range(1, 40), 64'h0, 1'b0, 30, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_det_ctrl.md
Name: pattern_det_ctrl

Overview:
Programmable serial pattern-detector controller: configures the target bit pattern and length, sequences one detection frame of a fixed number of serial bits, and counts matches. Detection is Mealy-style, like the fixed 101 detector: match output y responds combinationally to the current input bit. The block sits between a host (config/start/abort) and a serial bit source (x/x_valid).

Parameters:
PAT_W, 4, maximum pattern length in bits (1..8)
CNT_W, 8, match counter width
FRAME_W, 8, frame length field width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
cfg_we  input  1  config write strobe, honoured only in IDLE
cfg_pat  input  PAT_W  pattern; bit [len-1] is the first bit received, bit 0 the last
cfg_len  input  4  pattern length; legal values are 1..PAT_W
start  input  1  begin frame, honoured only in IDLE
frame_len  input  FRAME_W  number of bits in the frame; sampled at start
abort  input  1  terminate the running frame
x  input  1  serial data bit
x_valid  input  1  x is valid this cycle
y  output  1  combinational match pulse for the current bit
busy  output  1  high in RUN
done  output  1  one-cycle pulse at the end of a frame
match_cnt  output  CNT_W  matches found in the current or last frame
err  output  1  sticky illegal-config flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on port reset: sampled only on the rising edge of clk, active when reset=0.
- Reset values:
  - State IDLE.
  - pattern=0; len=PAT_W.
  - History, seen, bit_cnt = 0.
  - busy=0, done=0, match_cnt=0, err=0. y=0 because the state is not RUN.
  - Reset mid-frame aborts immediately: no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - cfg_we with 1<=cfg_len<=PAT_W: latch pattern/len, clear err.
  - cfg_we with cfg_len=0 or cfg_len>PAT_W: err<=1, config unchanged.
  - cfg_we outside IDLE is ignored.
  - start with frame_len!=0: go to RUN; clear match_cnt, bit_cnt, seen and history; latch frame_len.
  - start with frame_len=0: go to DONE; clear match_cnt.
  - cfg_we and start in the same cycle: the config is written and the frame runs with the new config.
- RUN:
  - busy=1.
  - Each cycle with x_valid=1 consumes one bit:
    - history <= {history[PAT_W-2:0], x}; newest bit is the LSB.
    - seen <= min(seen+1, PAT_W); bit_cnt++.
  - x_valid=0: nothing changes and y=0.
  - y = x_valid & (seen >= len-1) & ({history,x} low len bits == pattern low len bits).
  - On y: match_cnt increments, saturating at all-ones (no wrap).
  - Consuming the last bit (bit_cnt == frame_len-1): go to DONE. y may assert on this bit.
  - abort: go to IDLE next edge, no done, match_cnt holds. abort takes priority over the last-bit transition.
  - start and cfg_we in RUN are ignored.
- DONE: done=1 for exactly one cycle, then IDLE. match_cnt holds until the next accepted start.
- Latency: y in the same cycle as the completing bit; match_cnt updates one edge later; done one cycle after the last-bit edge.
- Bits presented while not in RUN are ignored.

Optional Feature:
OVERLAP_EN.
- Defined: overlapping detection. After a match, history and seen are kept, so a match suffix can start the next match.
- Undefined (default): non-overlapping, matching the fixed detector's return-to-start behaviour. On a match, seen<=0 and history<=0; the matched bit is not reused.

Test Plan:
- Pattern match, non-overlap: reset, cfg 101 len 3, frame_len 8, bits 1,0,1,0,1,1,0,1 -> y at bits 2 and 7, done one cycle after bit 7, match_cnt=2. With OVERLAP_EN -> y at bits 2, 4, 7, match_cnt=3.
- Bubbles: same stream with x_valid=0 inserted between every bit -> identical match positions, y=0 on every bubble cycle, done after the 8th valid bit.
- Config errors:
  - cfg_len=0 -> err=1, pattern unchanged.
  - Valid cfg -> err=0.
  - cfg_we during RUN -> ignored, frame result unchanged.
- Saturation: CNT_W=2, cfg pattern 1 len 1, frame_len 6, all ones -> match_cnt saturates at 3.
- Zero-length frame: start with frame_len=0 -> DONE next cycle, done pulse, match_cnt=0, busy never high.
- Abort and reset mid-frame:
  - abort after 3 bits -> IDLE, no done, match_cnt keeps its partial value.
  - reset=0 for one edge during RUN -> all outputs at reset values, no done pulse.
